// File: rtl/cfg_rst_boot_seq_pkg.sv
// Shared definitions for the power-on reset sequencer and multiboot controller:
// state encodings and the counter-width helper.
package cfg_rst_boot_pkg;

  typedef enum logic [2:0] {
    POR_HOLD = 3'd0,
    RELEASE  = 3'd1,
    RUN      = 3'd2,
    REBOOT   = 3'd3,
    FAIL     = 3'd4
  } state_e;

  localparam int STATE_W = 3;

  // Smallest width that can hold maxCount-1, never narrower than one bit.
  function automatic int cntWidth(input int maxCount);
    return (maxCount > 1) ? $clog2(maxCount) : 1;
  endfunction

endpackage

// File: rtl/cfg_rst_boot_seq_if.sv
// Boot-control bundle between the sequencer (master), the firmware-facing
// boot status and the MULTIBOOT primitive (slave).
interface cfg_rst_boot_seq_if
  import cfg_rst_boot_pkg::*;
#(
  parameter int N_IMG  = 2,
  parameter int ADDR_W = 32
);

  localparam int IDX_W = cntWidth(N_IMG);

  logic [N_IMG*ADDR_W-1:0] img_addr_i;
  logic                    boot_done_i;
  logic                    force_reboot_i;
  logic [ADDR_W-1:0]       mspim_addr_o;
  logic                    autoreboot_o;
  logic [IDX_W-1:0]        img_idx_o;
  logic                    boot_fail_o;

  modport master (
    input  img_addr_i, boot_done_i, force_reboot_i,
    output mspim_addr_o, autoreboot_o, img_idx_o, boot_fail_o
  );

  modport slave (
    output img_addr_i, boot_done_i, force_reboot_i,
    input  mspim_addr_o, autoreboot_o, img_idx_o, boot_fail_o
  );

endinterface

// File: rtl/cfg_rst_boot_seq_sync.sv
// Two-flop synchroniser for an asynchronous active-low reset input.
module cfg_rst_sync (
  input  logic lf_clk,
  input  logic resetn,
  input  logic rst_async_n_i,
  output logic rst_sync_n_o
);

  logic [1:0] sync_q;

  // Cleared to the deasserted value so a resetn release does not add
  // two extra cycles of ext-reset before the POR hold starts counting.
  always_ff @(posedge lf_clk) begin
    if (!resetn) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rst_async_n_i};
    end
  end

  assign rst_sync_n_o = sync_q[1];

endmodule

// File: rtl/cfg_rst_boot_seq.sv
// Power-on reset sequencer: POR hold, staged channel release, boot watchdog
// and multiboot image stepping with failure reporting.
module cfg_rst_boot_seq
  import cfg_rst_boot_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int N_CH      = 4,
  parameter int STAGE_GAP = 16,
  parameter int N_IMG     = 2,
  parameter int ADDR_W    = 32,
  parameter int WDT_CYC   = 1024
) (
  input  logic                      lf_clk,
  input  logic                      resetn,
  input  logic                      ext_rst_n_i,
  input  logic                      test_mode_i,
  cfg_rst_boot_seq_if.master        boot_if,
  output logic [N_CH-1:0]           rst_n_o,
  output logic                      loop_test_rst_n_o,
  output logic                      boot_rst_n_o,
  output logic [STATE_W-1:0]        state_o
);

  localparam int GAP_W = cntWidth(STAGE_GAP);
  localparam int WDT_W = cntWidth(WDT_CYC);
  localparam int STG_W = cntWidth(N_CH);
  localparam int IDX_W = cntWidth(N_IMG);

  localparam logic [CNT_W-1:0] POR_LAST = '1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(STAGE_GAP - 1);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYC - 1);
  localparam logic [STG_W-1:0] STG_LAST = STG_W'(N_CH - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IMG - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  por_cnt_q, por_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [STG_W-1:0]  stage_idx_q, stage_idx_d;
  logic [WDT_W-1:0]  wdt_cnt_q, wdt_cnt_d;
  logic [IDX_W-1:0]  img_idx_q, img_idx_d;
  logic [N_CH-1:0]   rst_n_q, rst_n_d;
  logic              test_lat_q, test_lat_d;
  logic              boot_ok_q, boot_ok_d;
  logic              extSyncN;
  logic              coreRst;

  cfg_rst_sync u_ext_sync (
    .lf_clk        (lf_clk),
    .resetn        (resetn),
    .rst_async_n_i (ext_rst_n_i),
    .rst_sync_n_o  (extSyncN)
  );

  assign coreRst = !resetn || !extSyncN;

  always_ff @(posedge lf_clk) begin
    if (coreRst) begin
      state_q     <= POR_HOLD;
      por_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      stage_idx_q <= '0;
      wdt_cnt_q   <= '0;
      img_idx_q   <= '0;
      rst_n_q     <= '0;
      test_lat_q  <= 1'b0;
      boot_ok_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      por_cnt_q   <= por_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      stage_idx_q <= stage_idx_d;
      wdt_cnt_q   <= wdt_cnt_d;
      img_idx_q   <= img_idx_d;
      rst_n_q     <= rst_n_d;
      test_lat_q  <= test_lat_d;
      boot_ok_q   <= boot_ok_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    por_cnt_d   = por_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    stage_idx_d = stage_idx_q;
    wdt_cnt_d   = wdt_cnt_q;
    img_idx_d   = img_idx_q;
    rst_n_d     = rst_n_q;
    test_lat_d  = test_lat_q;
    boot_ok_d   = boot_ok_q;

    unique case (state_q)
      POR_HOLD: begin
        por_cnt_d = por_cnt_q + 1'b1;
        if (por_cnt_q == POR_LAST) begin
          por_cnt_d   = '0;
          test_lat_d  = test_mode_i;
          gap_cnt_d   = '0;
          stage_idx_d = '0;
          state_d     = RELEASE;
        end
      end

      RELEASE: begin
        gap_cnt_d = gap_cnt_q + 1'b1;
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          rst_n_d   = rst_n_q | (N_CH'(1) << stage_idx_q);
          // The last stage index is never incremented, so it cannot wrap.
          if (stage_idx_q == STG_LAST) begin
            wdt_cnt_d = '0;
            state_d   = RUN;
          end else begin
            stage_idx_d = stage_idx_q + 1'b1;
          end
        end
      end

      RUN: begin
        if (!test_lat_q) begin
          if (boot_if.force_reboot_i) begin
            rst_n_d = '0;
            state_d = REBOOT;
          end else begin
            if (boot_if.boot_done_i) begin
              boot_ok_d = 1'b1;
            end
            if (!boot_ok_q) begin
              wdt_cnt_d = wdt_cnt_q + 1'b1;
              if (wdt_cnt_q == WDT_LAST) begin
                wdt_cnt_d = '0;
                rst_n_d   = '0;
                state_d   = REBOOT;
              end
            end
          end
        end
      end

      REBOOT: begin
        rst_n_d = '0;
        if (img_idx_q == IDX_LAST) begin
          state_d = FAIL;
        end else begin
          img_idx_d   = img_idx_q + 1'b1;
          boot_ok_d   = 1'b0;
          wdt_cnt_d   = '0;
          gap_cnt_d   = '0;
          stage_idx_d = '0;
          state_d     = RELEASE;
        end
      end

      FAIL: begin
        rst_n_d = '0;
      end

      default: begin
        por_cnt_d = '0;
        rst_n_d   = '0;
        state_d   = POR_HOLD;
      end
    endcase
  end

  assign rst_n_o              = rst_n_q;
  assign loop_test_rst_n_o    = rst_n_q[0] & test_lat_q;
  assign boot_rst_n_o         = rst_n_q[0] & ~test_lat_q;
  assign state_o              = state_q;
  assign boot_if.mspim_addr_o = boot_if.img_addr_i[img_idx_q*ADDR_W +: ADDR_W];
  assign boot_if.autoreboot_o = (state_q == REBOOT);
  assign boot_if.boot_fail_o  = (state_q == FAIL);
  assign boot_if.img_idx_o    = img_idx_q;

endmodule

// File: doc/cfg_rst_boot_seq.md
Name: cfg_rst_boot_seq

Overview:
Parametrised power-on reset sequencer and multiboot controller, clocked from the oscillator low-frequency output.
- Holds a programmable POR interval, then releases N_CH reset channels in timed stages.
- Steers a latched test-mode strap into separate loop-test and boot reset outputs.
- Supervises boot with a watchdog. On timeout or forced reboot it advances through N_IMG SPI image addresses, pulses AUTOREBOOT and re-sequences resets. It reports failure once all images are exhausted.
- Sits between the oscillator and the config clock/reset core, LMMI and MULTIBOOT primitives.

Parameters:
- CNT_W, 8: POR hold counter width; hold lasts 2^CNT_W cycles.
- N_CH, 4: number of staged reset channels (>=1).
- STAGE_GAP, 16: lf_clk cycles between successive channel releases (>=1).
- N_IMG, 2: number of boot images (>=1).
- ADDR_W, 32: SPI image address width.
- WDT_CYC, 1024: boot watchdog timeout in cycles (>=2).

Ports:
- lf_clk, in, 1: low-frequency oscillator clock.
- resetn, in, 1: synchronous, active-low reset; clock lf_clk.
- ext_rst_n_i, in, 1: asynchronous external reset, active-low; synchronised internally.
- test_mode_i, in, 1: test strap; latched when POR completes.
- img_addr_i, in, N_IMG*ADDR_W: image base addresses; slice i is bits [i*ADDR_W +: ADDR_W].
- boot_done_i, in, 1: level or pulse from firmware indicating a successful boot.
- force_reboot_i, in, 1: single-cycle request to advance to the next image.
- rst_n_o, out, N_CH: staged active-low channel resets.
- loop_test_rst_n_o, out, 1: rst_n_o[0] & test_lat.
- boot_rst_n_o, out, 1: rst_n_o[0] & ~test_lat.
- mspim_addr_o, out, ADDR_W: currently selected image address, combinational from img_idx.
- autoreboot_o, out, 1: one-cycle reboot strobe to MULTIBOOT.
- img_idx_o, out, $clog2(N_IMG) (min 1): current image index.
- boot_fail_o, out, 1: all images exhausted.
- state_o, out, 3: current state encoding.

Behaviour:
- States and encodings: POR_HOLD=0, RELEASE=1, RUN=2, REBOOT=3, FAIL=4.
- Reset (resetn=0 at a clock edge):
  - state POR_HOLD; por_cnt, gap_cnt, stage_idx, wdt_cnt, img_idx all 0.
  - test_lat=0, boot_ok=0, boot_fail_o=0.
  - rst_n_o=0, loop_test_rst_n_o=0, boot_rst_n_o=0, autoreboot_o=0.
  - mspim_addr_o equals image 0.
- ext_rst_n_i uses a 2-flop synchroniser. Synchronised low, from any state, has the same effect as resetn, except the synchroniser flops themselves are not cleared by it. Latency is 2-3 cycles from the input edge.
- POR_HOLD:
  - por_cnt increments every cycle.
  - On the edge where por_cnt == 2^CNT_W-1: latch test_mode_i into test_lat, clear gap_cnt and stage_idx, go to RELEASE.
  - RELEASE is therefore visible after the 2^CNT_W-th edge with reset deasserted.
- RELEASE:
  - gap_cnt increments each cycle.
  - On the edge where gap_cnt == STAGE_GAP-1: set rst_n_o[stage_idx]=1, clear gap_cnt, increment stage_idx.
  - Channel k is released STAGE_GAP*(k+1) cycles after RELEASE entry.
  - The same edge that releases channel N_CH-1 enters RUN with wdt_cnt=0.
  - Released channels stay released until REBOOT, FAIL or a reset.
- RUN, test_lat=1: watchdog disabled, force_reboot_i ignored; the block stays in RUN indefinitely.
- RUN, test_lat=0:
  - boot_done_i sets boot_ok (sticky until reset); the watchdog then stops.
  - While boot_ok=0, wdt_cnt increments. On the edge where wdt_cnt == WDT_CYC-1, go to REBOOT.
  - force_reboot_i=1 goes to REBOOT regardless of boot_ok.
  - If force_reboot_i and boot_done_i occur in the same cycle, force_reboot_i wins.
- REBOOT (exactly one cycle):
  - autoreboot_o=1; all rst_n_o=0.
  - If img_idx == N_IMG-1: go to FAIL.
  - Otherwise: img_idx increments, boot_ok clears, wdt_cnt/gap_cnt/stage_idx clear, go to RELEASE. The POR hold is not repeated.
  - mspim_addr_o shows the new image from the cycle after REBOOT.
- FAIL:
  - boot_fail_o=1; rst_n_o held 0; autoreboot_o=0; img_idx held.
  - Exits only via resetn or synchronised ext reset.
- Derived outputs: loop_test_rst_n_o and boot_rst_n_o are combinational from registered rst_n_o[0] and test_lat; the two are never high together.
- All counters saturate-free. Each counter's width holds its maximum compare value; compares are exact equality, and no counter is ever allowed to wrap.

Decomposition:
- Shared package cfg_rst_boot_pkg holds:
  - the state enum/localparams with the encodings above;
  - localparam helper for counter widths ($clog2 of STAGE_GAP, WDT_CYC, N_CH, N_IMG, minimum 1).
- One sub-module: cfg_rst_sync, a 2-flop active-low reset synchroniser, reused for ext_rst_n_i.

Test Plan (parameters: CNT_W=4, N_CH=3, STAGE_GAP=4, N_IMG=2, WDT_CYC=32, test_mode_i=0):
- POR and staging: resetn low then high at edge 0 -> state RELEASE after edge 16. rst_n_o goes 001 at 20, 011 at 24, 111 at 28. RUN at 28; boot_rst_n_o=1 from 20, loop_test_rst_n_o=0 throughout.
- Watchdog reboot: no boot_done_i -> REBOOT at edge 60 with autoreboot_o=1 for one cycle and rst_n_o=000. img_idx_o=1, mspim_addr_o=img_addr_i[63:32], RELEASE from 61, rst_n_o=111 at 73.
- Exhaustion: second timeout -> FAIL, boot_fail_o=1, rst_n_o stays 000. resetn pulse -> img_idx_o=0, boot_fail_o=0, POR restarts.
- Boot success: boot_done_i pulse at edge 40 -> no REBOOT through 200 cycles. force_reboot_i at 100 together with boot_done_i -> REBOOT at 101.
- Test mode: test_mode_i=1 at edge 15, flipped to 0 at 17 -> loop_test_rst_n_o=1 from 20, boot_rst_n_o=0. No reboot after 500 cycles, force_reboot_i ignored.
- Ext reset mid-RELEASE: ext_rst_n_i low at edge 22 for 1 cycle -> within 3 edges state POR_HOLD, rst_n_o=000, counters restart. Full sequence repeats with identical relative timing.
